// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - far-end UART peer that checks received frames and echoes good bytes
// A receive FSM feeds a small FIFO; a transmit FSM replays the buffered bytes in the same frame format.
module uart_echo_responder #(
  parameter int CLOCK_HZ   = 50000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic       echo_enable,
  input  logic       tx_pause,
  input  logic       rx_serial,
  output logic       tx_serial,
  output logic [7:0] data_out,
  output logic       rx_done_flag,
  output logic [2:0] error_flag,
  output logic       tx_active_flag,
  output logic       tx_done_flag,
  output logic       overflow_flag,
  output logic [2:0] fifo_level
);
  localparam int DIV_2400  = (CLOCK_HZ + 8 * 2400) / (16 * 2400);
  localparam int DIV_4800  = (CLOCK_HZ + 8 * 4800) / (16 * 4800);
  localparam int DIV_9600  = (CLOCK_HZ + 8 * 9600) / (16 * 9600);
  localparam int DIV_19200 = (CLOCK_HZ + 8 * 19200) / (16 * 19200);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  function automatic logic [15:0] div_sel(input logic [1:0] sel);
    logic [15:0] div;
    case (sel)
      2'b00:   div = 16'(DIV_2400);
      2'b01:   div = 16'(DIV_4800);
      2'b10:   div = 16'(DIV_9600);
      default: div = 16'(DIV_19200);
    endcase
    return div;
  endfunction

  function automatic logic parity_on(input logic [1:0] sel);
    return (sel == 2'b01) || (sel == 2'b10);
  endfunction

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  rx_state_t   rx_state, rx_next;
  tx_state_t   tx_state, tx_next;
  logic        rx_s1, rx_s2, rx_s3;
  logic [1:0]  baud_prev;
  logic        baud_chg;
  logic [15:0] rx_div, rx_cnt, tx_div, tx_cnt;
  logic [3:0]  rx_tick_idx, tx_tick_idx;
  logic [2:0]  rx_bit, tx_bit;
  logic [1:0]  rx_par, tx_par;
  logic [7:0]  rx_shift, tx_byte;
  logic [2:0]  rx_err;
  logic        rx_tick, rx_mid, rx_end, tx_tick, tx_end;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        push_req, push, pop;

  assign baud_chg = baud_rate != baud_prev;

  // Each bit spans 16 ticks; the receiver samples on tick 7, the middle of the bit.
  assign rx_tick = (rx_state != RX_IDLE) && (rx_cnt == rx_div - 16'd1);
  assign rx_mid  = rx_tick && (rx_tick_idx == 4'd7);
  assign rx_end  = rx_tick && (rx_tick_idx == 4'd15);
  assign tx_tick = (tx_state != TX_IDLE) && (tx_cnt == tx_div - 16'd1);
  assign tx_end  = tx_tick && (tx_tick_idx == 4'd15);

  assign rx_done_flag   = rx_state == RX_DONE;
  assign tx_active_flag = tx_state != TX_IDLE;
  assign fifo_level     = 3'(count);

  assign push_req = (rx_state == RX_DONE) && (rx_err == 3'b000) && echo_enable;
  assign pop      = (tx_state == TX_IDLE) && (count != '0) && !tx_pause;
  assign push     = push_req && ((count != FULL_LEVEL) || pop);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_s3 && !rx_s2) rx_next = RX_START;
      RX_START:  if (rx_mid && rx_s2) rx_next = RX_DONE;
                 else if (rx_end) rx_next = RX_DATA;
      RX_DATA:   if (rx_end && rx_bit == 3'd7) rx_next = parity_on(rx_par) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_end) rx_next = RX_STOP;
      RX_STOP:   if (rx_mid) rx_next = RX_DONE;
      RX_DONE:   rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_s3       <= 1'b1;
      baud_prev   <= baud_rate;
      rx_div      <= 16'd1;
      rx_cnt      <= '0;
      rx_tick_idx <= '0;
      rx_bit      <= '0;
      rx_par      <= '0;
      rx_shift    <= '0;
      rx_err      <= '0;
      data_out    <= '0;
      error_flag  <= '0;
    end else begin
      rx_state  <= rx_next;
      rx_s1     <= rx_serial;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      baud_prev <= baud_rate;
      if (rx_state == RX_IDLE || rx_tick || baud_chg) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 16'd1;
      // Frame settings are captured continuously while idle, so the edge clock's values stick.
      if (rx_state == RX_IDLE) begin
        rx_tick_idx <= '0;
        rx_bit      <= '0;
        rx_err      <= '0;
        rx_div      <= div_sel(baud_rate);
        rx_par      <= parity_type;
      end else if (rx_tick) begin
        rx_tick_idx <= rx_tick_idx + 4'd1;
      end
      if (rx_state == RX_START && rx_mid && rx_s2) rx_err[1] <= 1'b1;
      if (rx_state == RX_DATA && rx_mid) rx_shift <= {rx_s2, rx_shift[7:1]};
      if (rx_state == RX_DATA && rx_end) rx_bit <= rx_bit + 3'd1;
      if (rx_state == RX_PARITY && rx_mid && (((^rx_shift) ^ rx_s2) != (rx_par == 2'b01)))
        rx_err[0] <= 1'b1;
      if (rx_state == RX_STOP && rx_mid && !rx_s2) rx_err[2] <= 1'b1;
      if (rx_state == RX_DONE) begin
        error_flag <= rx_err;
        if (!rx_err[1]) data_out <= rx_shift;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_flag <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push_req && !push) overflow_flag <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= rx_shift;
  end

  always_comb begin
    tx_next   = tx_state;
    tx_serial = 1'b1;
    case (tx_state)
      TX_IDLE:   if (pop) tx_next = TX_START;
      TX_START: begin
        tx_serial = 1'b0;
        if (tx_end) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_serial = tx_byte[tx_bit];
        if (tx_end && tx_bit == 3'd7) tx_next = parity_on(tx_par) ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_serial = (^tx_byte) ^ (tx_par == 2'b01);
        if (tx_end) tx_next = TX_STOP;
      end
      TX_STOP:   if (tx_end) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state     <= TX_IDLE;
      tx_div       <= 16'd1;
      tx_cnt       <= '0;
      tx_tick_idx  <= '0;
      tx_bit       <= '0;
      tx_par       <= '0;
      tx_byte      <= '0;
      tx_done_flag <= 1'b0;
    end else begin
      tx_state     <= tx_next;
      tx_done_flag <= (tx_state == TX_STOP) && tx_end;
      if (tx_state == TX_IDLE || tx_tick || baud_chg) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 16'd1;
      if (tx_state == TX_IDLE) begin
        tx_tick_idx <= '0;
        tx_bit      <= '0;
        if (pop) begin
          tx_byte <= mem[rd_ptr];
          tx_div  <= div_sel(baud_rate);
          tx_par  <= parity_type;
        end
      end else if (tx_tick) begin
        tx_tick_idx <= tx_tick_idx + 4'd1;
      end
      if (tx_state == TX_DATA && tx_end) tx_bit <= tx_bit + 3'd1;
    end
  end
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb/tb_uart_echo_responder.sv - randomized self-checking bench for uart_echo_responder
// Drives serial frames, predicts rx results and echoes from frame rules, decodes tx_serial independently.
module tb_uart_echo_responder;
  localparam int CLK_HZ = 614400;
  localparam int DEPTH  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] baud_rate = 2'b10;
  logic [1:0] parity_type = 2'b01;
  logic       echo_enable = 1'b1;
  logic       tx_pause = 1'b0;
  logic       rx_serial = 1'b1;
  logic       tx_serial;
  logic [7:0] data_out;
  logic       rx_done_flag;
  logic [2:0] error_flag;
  logic       tx_active_flag;
  logic       tx_done_flag;
  logic       overflow_flag;
  logic [2:0] fifo_level;

  int total = 0, bad = 0, cyc = 0;
  int rx_done_cnt = 0, tx_done_cnt = 0, rst_epoch = 0;
  int last_rx_done_cyc = 0, last_tx_start_cyc = 0;
  int mdl_held = 0;
  int mdl_ovf = 0;
  logic [7:0] exp_q[$];

  uart_echo_responder #(.CLOCK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .baud_rate(baud_rate), .parity_type(parity_type),
    .echo_enable(echo_enable), .tx_pause(tx_pause), .rx_serial(rx_serial),
    .tx_serial(tx_serial), .data_out(data_out), .rx_done_flag(rx_done_flag),
    .error_flag(error_flag), .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag),
    .overflow_flag(overflow_flag), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_done_flag) begin
      rx_done_cnt++;
      last_rx_done_cyc = cyc;
    end
    if (tx_done_flag) tx_done_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bit_clks(input logic [1:0] b);
    case (b)
      2'b00:   return CLK_HZ / 2400;
      2'b01:   return CLK_HZ / 4800;
      2'b10:   return CLK_HZ / 9600;
      default: return CLK_HZ / 19200;
    endcase
  endfunction

  function automatic bit par_on(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  // Odd parity makes the total count of ones odd, even parity makes it even.
  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] p);
    int ones;
    ones = $countones(d);
    return (p == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    int bc;
    logic [1:0] p;
    logic bits[$];
    bc = bit_clks(baud_rate);
    p = parity_type;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_on(p)) bits.push_back(par_bit(d, p) ^ bad_par);
    bits.push_back(!bad_stop);
    foreach (bits[i]) begin
      rx_serial = bits[i];
      repeat (bc) @(negedge clock);
    end
    rx_serial = 1'b1;
    repeat (bc) @(negedge clock);
  endtask

  task automatic send_and_check(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    int rd;
    logic [2:0] exp_err;
    exp_err = {bad_stop, 1'b0, par_on(parity_type) & bad_par};
    rd = rx_done_cnt;
    send_frame(d, bad_par, bad_stop);
    chk("rx_done_pulses", rx_done_cnt - rd, 1);
    chk("rx_error_flag", error_flag, exp_err);
    chk("rx_data_out", data_out, d);
    if (exp_err == 3'b000 && echo_enable) begin
      if (mdl_held < DEPTH) begin
        exp_q.push_back(d);
        if (tx_pause) mdl_held++;
      end else begin
        mdl_ovf = 1;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((fifo_level != 0 || tx_active_flag) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("drained", (fifo_level == 0 && !tx_active_flag) ? 1 : 0, 1);
    repeat (4) @(negedge clock);
  endtask

  task automatic check_reset_state();
    chk("rst_tx_serial", tx_serial, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_rx_done", rx_done_flag, 0);
    chk("rst_error_flag", error_flag, 0);
    chk("rst_tx_active", tx_active_flag, 0);
    chk("rst_tx_done", tx_done_flag, 0);
    chk("rst_overflow", overflow_flag, 0);
    chk("rst_fifo_level", fifo_level, 0);
  endtask

  task automatic decode_echo();
    int bc, c0, ep, n;
    logic [1:0] p;
    logic [7:0] d;
    logic pb, sb;
    bit pon;
    bc = bit_clks(baud_rate);
    p = parity_type;
    pon = par_on(p);
    c0 = cyc;
    ep = rst_epoch;
    last_tx_start_cyc = cyc;
    pb = 1'b0;
    repeat (bc / 2) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      repeat (bc) @(negedge clock);
      d[i] = tx_serial;
    end
    if (pon) begin
      repeat (bc) @(negedge clock);
      pb = tx_serial;
    end
    repeat (bc) @(negedge clock);
    sb = tx_serial;
    n = 0;
    while (!tx_done_flag && n < 2 * bc) begin
      @(negedge clock);
      n++;
    end
    if (ep != rst_epoch) return;
    chk("tx_stop_bit", sb, 1);
    if (pon) chk("tx_parity_bit", pb, par_bit(d, p));
    chk("tx_frame_clks", cyc - c0, (pon ? 11 : 10) * bc);
    chk("echo_expected", (exp_q.size() != 0) ? 1 : 0, 1);
    if (exp_q.size() != 0) chk("echo_byte", d, exp_q.pop_front());
  endtask

  initial begin : tx_mon
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && prev && !tx_serial) begin
        decode_echo();
        prev = 1'b1;
      end else begin
        prev = tx_serial;
      end
    end
  end

  initial begin : main
    int td, rd, bc;
    logic [7:0] keep;
    repeat (5) @(negedge clock);
    check_reset_state();
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // 9600 odd parity echo with latency and frame timing
    td = tx_done_cnt;
    send_and_check(8'hAA, 1'b0, 1'b0);
    wait_idle();
    chk("echo_latency", last_tx_start_cyc - last_rx_done_cyc, 2);
    chk("tx_done_pulses", tx_done_cnt - td, 1);

    // 19200 even parity: good frame echoes, bad parity is dropped
    baud_rate = 2'b11;
    parity_type = 2'b10;
    send_and_check(8'h5C, 1'b0, 1'b0);
    wait_idle();
    send_and_check(8'h5C, 1'b1, 1'b0);
    chk("bad_parity_level", fifo_level, 0);
    wait_idle();

    // stop error and a short start glitch
    send_and_check(8'h3C, 1'b0, 1'b1);
    chk("bad_stop_level", fifo_level, 0);
    keep = data_out;
    rd = rx_done_cnt;
    bc = bit_clks(baud_rate);
    rx_serial = 1'b0;
    repeat (4 * bc / 16) @(negedge clock);
    rx_serial = 1'b1;
    repeat (2 * bc) @(negedge clock);
    chk("glitch_error", error_flag, 3'b010);
    chk("glitch_data_kept", data_out, keep);
    chk("glitch_done_pulse", rx_done_cnt - rd, 1);
    wait_idle();

    // paused transmitter: overflow after four buffered bytes
    baud_rate = 2'b10;
    parity_type = 2'b01;
    tx_pause = 1'b1;
    td = tx_done_cnt;
    for (int i = 1; i <= 5; i++) send_and_check(8'(i), 1'b0, 1'b0);
    chk("paused_level", fifo_level, mdl_held);
    chk("paused_overflow", overflow_flag, mdl_ovf);
    chk("paused_no_tx", tx_done_cnt - td, 0);
    tx_pause = 1'b0;
    mdl_held = 0;
    wait_idle();
    chk("released_tx_count", tx_done_cnt - td, 4);
    chk("overflow_sticky", overflow_flag, 1);
    chk("released_queue", exp_q.size(), 0);

    // baud change mid-frame applies only to the next frame
    baud_rate = 2'b10;
    fork
      send_and_check(8'hC3, 1'b0, 1'b0);
      begin
        repeat (4 * bit_clks(2'b10)) @(negedge clock);
        baud_rate = 2'b11;
      end
    join
    wait_idle();
    send_and_check(8'h96, 1'b0, 1'b0);
    wait_idle();

    // randomized frames
    for (int k = 0; k < 8; k++) begin
      logic [7:0] d;
      bit bp, bs;
      baud_rate = 2'($urandom_range(1, 3));
      parity_type = 2'($urandom_range(0, 3));
      echo_enable = ($urandom_range(0, 3) != 0);
      d = 8'($urandom_range(0, 255));
      bp = par_on(parity_type) && ($urandom_range(0, 4) == 0);
      bs = ($urandom_range(0, 5) == 0);
      send_and_check(d, bp, bs);
      wait_idle();
    end
    echo_enable = 1'b1;

    // reset in the middle of a transmit
    baud_rate = 2'b11;
    parity_type = 2'b00;
    bc = bit_clks(baud_rate);
    send_and_check(8'h77, 1'b0, 1'b0);
    repeat (bc) @(negedge clock);
    chk("tx_busy_before_reset", tx_active_flag, 1);
    reset = 1'b1;
    rst_epoch++;
    exp_q.delete();
    @(negedge clock);
    check_reset_state();
    reset = 1'b0;
    td = tx_done_cnt;
    repeat (12 * bc) @(negedge clock);
    chk("no_tx_done_after_reset", tx_done_cnt - td, 0);
    chk("tx_idle_after_reset", tx_serial, 1);

    // reset while the receiver is in its data bits
    rx_serial = 1'b0;
    repeat (3 * bc) @(negedge clock);
    reset = 1'b1;
    rx_serial = 1'b1;
    rst_epoch++;
    @(negedge clock);
    check_reset_state();
    reset = 1'b0;
    rd = rx_done_cnt;
    td = tx_done_cnt;
    repeat (12 * bc) @(negedge clock);
    chk("no_rx_done_after_reset", rx_done_cnt - rd, 0);
    chk("no_echo_after_rx_reset", tx_done_cnt - td, 0);

    wait_idle();
    chk("echo_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_echo_responder.md
Name: uart_echo_responder

Overview:
Remote-end UART peer for the duplex UART. It receives frames on a serial line, checks the start, parity and stop bits, and buffers good bytes in a 4-deep FIFO. It then retransmits each buffered byte back on its own serial output using the same frame format. It is the far end of the link, used for loopback bring-up and for closing the duplex path in system simulation.

Parameters:
CLOCK_HZ, 50000000, system clock frequency; sets the baud tick divisors.
FIFO_DEPTH, 4, echo buffer depth in bytes; must be a power of two.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
baud_rate  input  2  baud select: 00=2400, 01=4800, 10=9600, 11=19200.
parity_type  input  2  parity select: 00=none, 01=odd, 10=even, 11=none.
echo_enable  input  1  1 = good frames are pushed into the FIFO.
tx_pause  input  1  1 = the transmitter does not start a new frame.
rx_serial  input  1  serial line in; idles high.
tx_serial  output  1  serial line out; idles high.
data_out  output  8  last received byte.
rx_done_flag  output  1  1-cycle pulse at the end of every receive attempt.
error_flag  output  3  [0]=parity error, [1]=start error, [2]=stop error.
tx_active_flag  output  1  high while a frame is being transmitted.
tx_done_flag  output  1  1-cycle pulse after the transmitted stop bit.
overflow_flag  output  1  sticky; set when a good byte is dropped because the FIFO is full.
fifo_level  output  3  number of bytes held in the FIFO (0..4).

Behaviour:
- Reset values:
  - tx_serial=1; all other outputs 0.
  - FIFO emptied; both FSMs return to IDLE.
  - Synchronizer flops reset to 1.
  - Reset asserted mid-frame aborts the frame with no done pulse.
- Tick generation:
  - Tick period = round(CLOCK_HZ/(16*baud)) clocks: 1302, 651, 326 or 163 clocks at 50 MHz.
  - One bit period = 16 ticks.
  - The tick counter restarts whenever baud_rate changes.
- Frame format:
  - Start bit 0, then 8 data bits LSB first, then a parity bit only if parity_type is 01 or 10, then stop bit 1.
  - baud_rate and parity_type are latched at each frame start. Changes take effect on the next frame.
- rx_serial passes through a 2-flop synchronizer before any use.
- Receive FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE -> START on a synchronized 1->0 transition.
  - START: sample at tick 7. If the line is 1, set error_flag=010, go to DONE, and leave data_out unchanged.
  - DATA: sample each bit at its tick 7 (mid-bit).
  - PARITY: a mismatch sets bit 0 of error_flag.
  - STOP: a 0 sample sets bit 2 of error_flag.
  - DONE: lasts one clock. data_out updates, rx_done_flag pulses, error_flag takes its new value and holds until the next DONE. Then return to IDLE.
  - Good byte = error_flag==000. It is pushed at DONE if echo_enable=1. If the FIFO is full and there is no pop in the same cycle, the byte is dropped and overflow_flag is set.
- FIFO:
  - Push and pop in the same cycle both take effect.
  - A push to a full FIFO is accepted if a pop happens in the same cycle.
  - Bytes leave in arrival order.
  - Pointers wrap modulo FIFO_DEPTH.
- Transmit FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE pops a byte when the FIFO is not empty and tx_pause=0.
  - tx_serial drives the start bit from the clock after the pop. Each bit lasts 16 ticks.
  - tx_active_flag is high from START through STOP.
  - tx_done_flag pulses one clock after STOP ends, then the FSM returns to IDLE.
  - tx_pause does not abort a frame in progress.
- Latency:
  - The push occurs in the DONE clock.
  - The pop occurs in the next clock, if the transmitter is idle.
  - The start bit begins in the clock after the pop: 2 clocks after DONE.

Test Plan:
1. 9600 baud, odd parity, echo_enable=1: send 0xAA (line bits 0,0,1,0,1,0,1,0,1,1,1) -> data_out=AA, error_flag=000, one rx_done_flag pulse; tx_serial replays the same 11 bits at 5216 clocks per bit, then one tx_done_flag pulse.
2. 19200 baud, even parity: send 0x5C with parity bit 0 -> echoed with parity bit 0. Resend 0x5C with parity bit 1 -> error_flag=001, no echo, fifo_level stays 0.
3. Stop bit forced to 0 -> error_flag=100, no push. A 0 glitch lasting 4 ticks on an idle line -> error_flag=010, data_out unchanged.
4. tx_pause=1, 5 back-to-back good frames 0x01..0x05 -> fifo_level=4, overflow_flag=1. Release tx_pause -> echoes 01,02,03,04; 0x05 is never sent; overflow_flag stays 1 until reset.
5. Change baud_rate from 10 to 11 mid-frame -> the current frame completes at 9600; the next frame runs at 19200.
6. Assert reset in the DATA state of rx and again mid-transmit -> the next clock shows tx_serial=1, all flags 0, fifo_level=0, and no done pulses.
